// File: rtl/mc_sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkg
//  Brief    : Shared defaults and occupancy-count width helper for mc_sync_fifo
//  Revision : 1.0
// ============================================================================
package fifo_pkg;

    localparam int c_DEF_DATA_LEN = 16;
    localparam int c_DEF_ADDR_LEN = 4;
    localparam int c_DEF_NUM_CH   = 4;

    // One extra bit so a completely full channel (count == depth) is representable.
    function automatic int cnt_width(input int addr_len);
        return addr_len + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_sync_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : mc_sync_fifo_if
//  Brief    : Write/read request bus of the multi-channel FIFO
//  Revision : 1.0
// ============================================================================
interface mc_sync_fifo_if
    import fifo_pkg::*;
#(
    parameter int DATA_LEN = c_DEF_DATA_LEN,
    parameter int CH_LEN   = $clog2(c_DEF_NUM_CH)
);

    logic                wr_en;
    logic [CH_LEN-1:0]   wr_ch;
    logic [DATA_LEN-1:0] data_in;
    logic                rd_en;
    logic [CH_LEN-1:0]   rd_ch;
    logic [DATA_LEN-1:0] data_out;
    logic                rd_valid;

    modport master (
        output wr_en, wr_ch, data_in, rd_en, rd_ch,
        input  data_out, rd_valid
    );

    modport slave (
        input  wr_en, wr_ch, data_in, rd_en, rd_ch,
        output data_out, rd_valid
    );

endinterface
`default_nettype wire

// File: rtl/mc_sync_fifo_ch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_ch_ctrl
//  Brief    : Pointers, occupancy count and status flags of one FIFO channel
//  Revision : 1.0
// ============================================================================
module fifo_ch_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_LEN     = c_DEF_ADDR_LEN,
    parameter int AFULL_THRESH = (1 << ADDR_LEN) - 4
) (
    input  wire logic                          clk,
    input  wire logic                          reset,
    input  wire logic                          wr_req,
    input  wire logic                          rd_req,
    output logic                               wr_acc,
    output logic                               rd_acc,
    output logic [ADDR_LEN-1:0]                wr_ptr,
    output logic [ADDR_LEN-1:0]                rd_ptr,
    output logic [cnt_width(ADDR_LEN)-1:0]     count,
    output logic                               full,
    output logic                               empty,
    output logic                               afull,
    output logic                               ovf,
    output logic                               udf
);

    localparam int                 c_CNT_W = cnt_width(ADDR_LEN);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(1 << ADDR_LEN);
    localparam logic [c_CNT_W-1:0] c_AFULL = c_CNT_W'(AFULL_THRESH);

    logic [ADDR_LEN-1:0] r_wr_ptr;
    logic [ADDR_LEN-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_full;
    logic                r_empty;
    logic                r_afull;
    logic                r_ovf;
    logic                r_udf;
    logic [c_CNT_W-1:0]  w_count_nxt;

    // Acceptance looks only at registered flags, so a full channel rejects a
    // write even when a read of the same channel frees a slot this cycle.
    assign wr_acc      = wr_req & ~r_full;
    assign rd_acc      = rd_req & ~r_empty;
    assign w_count_nxt = r_count + c_CNT_W'(wr_acc) - c_CNT_W'(rd_acc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_LEN'(1);
            if (rd_acc) r_rd_ptr <= r_rd_ptr + ADDR_LEN'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_DEPTH);
            r_empty <= (w_count_nxt == '0);
            r_afull <= (w_count_nxt >= c_AFULL);
            r_ovf   <= r_ovf | (wr_req & r_full);
            r_udf   <= r_udf | (rd_req & r_empty);
        end
    end

    assign wr_ptr = r_wr_ptr;
    assign rd_ptr = r_rd_ptr;
    assign count  = r_count;
    assign full   = r_full;
    assign empty  = r_empty;
    assign afull  = r_afull;
    assign ovf    = r_ovf;
    assign udf    = r_udf;

endmodule
`default_nettype wire

// File: rtl/mc_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mc_sync_fifo
//  Brief    : Multi-channel synchronous FIFO over one shared {channel,pointer} RAM
//  Revision : 1.0
// ============================================================================
module mc_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_LEN     = c_DEF_DATA_LEN,
    parameter int ADDR_LEN     = c_DEF_ADDR_LEN,
    parameter int NUM_CH       = c_DEF_NUM_CH,
    parameter int AFULL_THRESH = (1 << ADDR_LEN) - 4
) (
    input  wire logic                                 clk,
    input  wire logic                                 reset,
    mc_sync_fifo_if.slave                             bus,
    output logic [NUM_CH-1:0]                         wrt_full,
    output logic [NUM_CH-1:0]                         rd_empty,
    output logic [NUM_CH-1:0]                         almost_full,
    output logic [NUM_CH*cnt_width(ADDR_LEN)-1:0]     count,
    output logic [NUM_CH-1:0]                         overflow,
    output logic [NUM_CH-1:0]                         underflow
);

    localparam int c_CH_LEN    = $clog2(NUM_CH);
    localparam int c_CNT_W     = cnt_width(ADDR_LEN);
    localparam int c_MEM_WORDS = NUM_CH << ADDR_LEN;

    logic [DATA_LEN-1:0]          r_mem [c_MEM_WORDS];
    logic [DATA_LEN-1:0]          r_data_out;
    logic                         r_rd_valid;
    logic [ADDR_LEN-1:0]          w_wr_ptr [NUM_CH];
    logic [ADDR_LEN-1:0]          w_rd_ptr [NUM_CH];
    logic [NUM_CH-1:0]            w_wr_acc;
    logic [NUM_CH-1:0]            w_rd_acc;
    logic [c_CH_LEN+ADDR_LEN-1:0] w_wr_addr;
    logic [c_CH_LEN+ADDR_LEN-1:0] w_rd_addr;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        fifo_ch_ctrl #(
            .ADDR_LEN     (ADDR_LEN),
            .AFULL_THRESH (AFULL_THRESH)
        ) u_ctrl (
            .clk    (clk),
            .reset  (reset),
            .wr_req (bus.wr_en && (bus.wr_ch == c_CH_LEN'(i))),
            .rd_req (bus.rd_en && (bus.rd_ch == c_CH_LEN'(i))),
            .wr_acc (w_wr_acc[i]),
            .rd_acc (w_rd_acc[i]),
            .wr_ptr (w_wr_ptr[i]),
            .rd_ptr (w_rd_ptr[i]),
            .count  (count[i*c_CNT_W +: c_CNT_W]),
            .full   (wrt_full[i]),
            .empty  (rd_empty[i]),
            .afull  (almost_full[i]),
            .ovf    (overflow[i]),
            .udf    (underflow[i])
        );
    end

    // At most one channel is addressed per direction, so an OR-reduce of the
    // per-channel accepts is the global write/read strobe.
    assign w_wr_addr = {bus.wr_ch, w_wr_ptr[bus.wr_ch]};
    assign w_rd_addr = {bus.rd_ch, w_rd_ptr[bus.rd_ch]};

    always_ff @(posedge clk) begin
        if (|w_wr_acc) r_mem[w_wr_addr] <= bus.data_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= |w_rd_acc;
            if (|w_rd_acc) r_data_out <= r_mem[w_rd_addr];
        end
    end

    assign bus.data_out = r_data_out;
    assign bus.rd_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: doc/mc_sync_fifo.md
MC_SYNC_FIFO -- requirements
Module: mc_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_LEN, default 16, data word width in bits.
REQ-002 SHALL have parameter ADDR_LEN, default 4, log2 of per-channel depth; FIFO_DEPTH = 1 << ADDR_LEN.
REQ-003 SHALL have parameter NUM_CH, default 4, number of independent channels (power of two, >= 2); CH_LEN = log2(NUM_CH).
REQ-004 SHALL have parameter AFULL_THRESH, default FIFO_DEPTH-4, occupancy at or above which almost_full asserts.
REQ-005 SHALL use one clock and an asynchronous, active-high reset; ports: clk input 1 rising-edge clock; reset input 1 asynchronous active-high reset.
REQ-006 wr_en input 1: write request.
REQ-007 wr_ch input CH_LEN: target channel of write.
REQ-008 data_in input DATA_LEN: write data.
REQ-009 rd_en input 1: read request.
REQ-010 rd_ch input CH_LEN: source channel of read.
REQ-011 data_out output DATA_LEN: registered read data.
REQ-012 rd_valid output 1: data_out carries a newly popped word this cycle.
REQ-013 wrt_full output NUM_CH: per-channel full flag.
REQ-014 rd_empty output NUM_CH: per-channel empty flag.
REQ-015 almost_full output NUM_CH: per-channel occupancy >= AFULL_THRESH.
REQ-016 count output NUM_CH*(ADDR_LEN+1): per-channel occupancy, channel c at bits [c*(ADDR_LEN+1) +: ADDR_LEN+1].
REQ-017 overflow, underflow outputs NUM_CH each: sticky per-channel error flags.

Function
REQ-018 Storage SHALL be one memory of NUM_CH*FIFO_DEPTH words addressed {channel, pointer}; each channel a circular buffer.
REQ-019 Write accepted iff wr_en & ~wrt_full[wr_ch]; word stored at channel write pointer, pointer increments modulo FIFO_DEPTH.
REQ-020 Read accepted iff rd_en & ~rd_empty[rd_ch]; word at channel read pointer loaded into data_out on the same edge, pointer increments modulo FIFO_DEPTH.
REQ-021 Read latency SHALL be 1 cycle: rd_valid high for exactly the cycle after an accepted read; data_out holds its value otherwise.
REQ-022 All flags and count SHALL be registered, updated on the edge that accepts the transfer; no combinational path from wr_en/rd_en to any flag.
REQ-023 Word written at edge N SHALL be readable from edge N+1 (rd_empty deasserts after edge N).
REQ-024 Simultaneous accepted write and read to the same channel: count unchanged, both pointers advance, flags unchanged.
REQ-025 Write to a full channel SHALL be dropped even if a read of that channel is accepted in the same cycle; overflow[wr_ch] set.
REQ-026 Read of an empty channel SHALL be dropped even if a write to that channel occurs same cycle; underflow[rd_ch] set, rd_valid stays 0.
REQ-027 Writes and reads to different channels SHALL proceed independently in the same cycle.
REQ-028 wrt_full[c] = (count[c] == FIFO_DEPTH); rd_empty[c] = (count[c] == 0); almost_full[c] = (count[c] >= AFULL_THRESH).
REQ-029 overflow/underflow SHALL remain set until reset.

Reset
REQ-030 Asserting reset SHALL immediately clear all pointers and counts, set rd_empty to all ones, clear wrt_full, almost_full, overflow, underflow, rd_valid, and zero data_out; memory contents not reset.
REQ-031 Reset mid-operation SHALL discard all stored words; first accepted write after deassertion lands at pointer 0.

Structure
REQ-032 A shared package fifo_pkg SHALL hold the default parameter constants and the occupancy-count width function.
REQ-033 Per-channel pointers, count, and flag logic SHALL be one sub-module fifo_ch_ctrl, instantiated NUM_CH times by generate.

Verification
REQ-034 Reset, then write 0x0001..0x0010 to ch 2 -> wrt_full[2]=1 after 16th write, count[2]=16, other channels rd_empty=1.
REQ-035 Read ch 2 sixteen times -> data_out 0x0001..0x0010 in order, each one cycle after rd_en, rd_empty[2]=1 after last.
REQ-036 17th write to full ch 0 concurrent with read of ch 0 -> write dropped, overflow[0]=1, count[0]=15.
REQ-037 Read empty ch 1 -> rd_valid=0, underflow[1]=1; write 0xBEEF ch 3 while reading ch 3 holding 1 word -> count[3]=1, no errors.
REQ-038 Fill ch 0 to 12 -> almost_full[0]=1 at 12, 0 at 11; 40 write/read pairs on ch 0 exercise pointer wrap, data order preserved.
REQ-039 Assert reset with ch 1 holding 5 words -> count[1]=0, rd_empty[1]=1 immediately, next write/read returns new data.
